// File: rtl/hzd_check_scanner_if.sv
// hzd_check_scanner_if: valid/ready byte stream from the scanner to a debug byte sink.
interface hzd_check_scanner_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/hzd_check_scanner.sv
// hzd_check_scanner: walks the check mux and streams a framed, XOR-checksummed byte snapshot.
module hzd_check_scanner #(
  parameter int         NUM_ENTRIES = 25,
  parameter logic [7:0] HEADER      = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  output logic [4:0]                 check_addr,
  input  logic [31:0]                check_data,
  hzd_check_scanner_if.master        tx,
  output logic                       busy,
  output logic                       done
);
  typedef enum logic [2:0] {IDLE, HDR, CAPT, BYTE, SUM} state_t;
  localparam logic [4:0] LAST = 5'(NUM_ENTRIES - 1);
  state_t      state, next;
  logic [31:0] word;
  logic [7:0]  sum;
  logic [1:0]  byte_idx;
  logic        acc;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= next;
  always_comb begin
    next     = state;
    tx.valid = state inside {HDR, BYTE, SUM};
    tx.data  = state == HDR  ? HEADER :
               state == BYTE ? word[{byte_idx, 3'b000} +: 8] :
               state == SUM  ? sum : 8'h00;
    acc      = tx.valid && tx.ready;
    case (state)
      IDLE:    next = start ? HDR : IDLE;
      HDR:     next = acc ? CAPT : HDR;
      CAPT:    next = BYTE;
      BYTE:    next = !(acc && byte_idx == 2'd3) ? BYTE : check_addr == LAST ? SUM : CAPT;
      SUM:     next = acc ? IDLE : SUM;
      default: next = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  // check_addr only advances once the last byte of an entry leaves, so the mux is stable through CAPT
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      check_addr <= '0;
      word       <= '0;
      sum        <= '0;
      byte_idx   <= '0;
      done       <= 1'b0;
    end else begin
      done <= state == SUM && acc;
      if (state == IDLE && start) sum <= '0;
      if (state == CAPT) begin
        word     <= check_data;
        byte_idx <= '0;
      end
      if (state == BYTE && acc) begin
        sum      <= sum ^ tx.data;
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3 && check_addr != LAST) check_addr <= check_addr + 5'd1;
      end
      if (state == SUM && acc) check_addr <= '0;
    end
endmodule

// File: tb/tb_hzd_check_scanner.sv
// tb_hzd_check_scanner: randomized and directed frame checks against a frame-level reference model.
module tb_hzd_check_scanner;
  logic clk = 1'b0, rstn = 1'b0, start0 = 1'b0, start1 = 1'b0;
  always #5 clk = ~clk;
  hzd_check_scanner_if tx0(), tx1();
  logic [4:0]  a0, a1;
  logic [31:0] cd0;
  logic        busy0, busy1, done0, done1;
  logic [31:0] tbl [32];
  bit          bad3 = 1'b0;
  int          n_tests = 0, n_fail = 0;
  logic [7:0]  rx0[$], rx1[$];
  int          busy_c0, done_c0, stall_c0, busy_c1, done_c1;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data;

  // corrupt the mux only while entry 3's bytes are on the wire (valid high), never during its capture
  assign cd0 = (bad3 && a0 == 5'd3 && tx0.valid) ? 32'hDEAD_BEEF : tbl[a0];

  hzd_check_scanner dut0 (.clk(clk), .rstn(rstn), .start(start0), .check_addr(a0), .check_data(cd0),
                          .tx(tx0), .busy(busy0), .done(done0));
  hzd_check_scanner #(.NUM_ENTRIES(1)) dut1 (.clk(clk), .rstn(rstn), .start(start1), .check_addr(a1),
                          .check_data(32'h1234_5678), .tx(tx1), .busy(busy1), .done(done1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!rstn) prev_stall = 1'b0;
    else begin
      if (prev_stall) chk("hold", {23'd0, tx0.valid, tx0.data}, {23'd0, 1'b1, prev_data});
      prev_stall = tx0.valid && !tx0.ready;
      prev_data  = tx0.data;
      busy_c0  += int'(busy0);
      done_c0  += int'(done0);
      stall_c0 += int'(busy0 && tx0.valid && !tx0.ready);
      if (tx0.valid && tx0.ready) rx0.push_back(tx0.data);
      busy_c1  += int'(busy1);
      done_c1  += int'(done1);
      if (tx1.valid && tx1.ready) rx1.push_back(tx1.data);
    end

  task automatic basic_table;
    for (int e = 0; e < 32; e++) tbl[e] = 32'h1000_0000 + e;
  endtask

  task automatic frame(input bit rnd, input int stall_e, input bit dbl, input bit rst_mid, input int exp_busy);
    logic [7:0] exp[$];
    logic [7:0] x = 8'h00;
    logic [7:0] v;
    int holds = 0, cyc = 0;
    bit aborted = 1'b0;
    rx0.delete();
    busy_c0 = 0; done_c0 = 0; stall_c0 = 0;
    exp.push_back(8'hA5);
    for (int e = 0; e < 25; e++)
      for (int b = 0; b < 4; b++) begin
        v = tbl[e][8*b +: 8];
        exp.push_back(v);
        x ^= v;
      end
    exp.push_back(x);
    tx0.ready = 1'b1;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    chk("hdr_now", {22'd0, busy0, tx0.valid, tx0.data}, {22'd0, 2'b11, 8'hA5});
    while (done_c0 == 0 && cyc < 2000) begin
      cyc++;
      if (stall_e >= 0 && holds < 3 && tx0.valid && rx0.size() == 1 + 4*stall_e) begin
        chk("bp_data", {24'd0, tx0.data}, stall_e);
        chk("bp_addr", {27'd0, a0}, stall_e);
        tx0.ready = 1'b0;
        holds++;
      end else tx0.ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      start0 = dbl && (rx0.size() == 10 || rx0.size() == 50);
      if (rst_mid && a0 == 5'd12) begin
        rstn = 1'b0;
        #1;
        chk("rst_outs", {19'd0, a0, tx0.valid, tx0.data, busy0, done0}, 32'd0);
        chk("rst_no_done", done_c0, 0);
        aborted = 1'b1;
        break;
      end
      tick;
    end
    start0 = 1'b0;
    tx0.ready = 1'b1;
    if (!aborted) begin
      repeat (6) tick;
      chk("len", rx0.size(), exp.size());
      foreach (exp[i]) if (i < rx0.size()) chk($sformatf("byte%0d", i), {24'd0, rx0[i]}, {24'd0, exp[i]});
      chk("busy_cycles", busy_c0, exp_busy < 0 ? 127 + stall_c0 : exp_busy);
      chk("done_cnt", done_c0, 1);
      chk("idle_after", {26'd0, busy0, a0}, 32'd0);
    end
  endtask

  initial begin
    int c;
    tx0.ready = 1'b1;
    tx1.ready = 1'b1;
    basic_table();
    repeat (2) tick;
    chk("reset_state", {19'd0, a0, tx0.valid, tx0.data, busy0, done0}, 32'd0);
    rstn = 1'b1;
    tick;
    frame(1'b0, -1, 1'b0, 1'b0, 127);
    if (rx0.size() == 102) chk("checksum", {24'd0, rx0[101]}, 32'h08);
    frame(1'b0, 5, 1'b0, 1'b0, 130);
    bad3 = 1'b1;
    frame(1'b0, -1, 1'b0, 1'b0, 127);
    bad3 = 1'b0;
    frame(1'b0, -1, 1'b1, 1'b0, 127);
    frame(1'b0, -1, 1'b0, 1'b1, 0);
    tick;
    rstn = 1'b1;
    tick;
    frame(1'b0, -1, 1'b0, 1'b0, 127);
    if (rx0.size() == 102) chk("checksum_after_rst", {24'd0, rx0[101]}, 32'h08);
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 32; e++) tbl[e] = $urandom;
      frame(1'b1, -1, 1'b0, 1'b0, -1);
    end
    basic_table();
    rx1.delete();
    busy_c1 = 0; done_c1 = 0;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    c = 0;
    while (done_c1 == 0 && c < 100) begin
      tick;
      c++;
    end
    repeat (3) tick;
    chk("p1_len", rx1.size(), 6);
    if (rx1.size() == 6)
      chk("p1_frame", {rx1[1], rx1[2], rx1[3], rx1[4]}, 32'h7856_3412);
    if (rx1.size() == 6) chk("p1_hdr_sum", {16'd0, rx1[0], rx1[5]}, 32'h0000_A508);
    chk("p1_busy", busy_c1, 7);
    chk("p1_done", done_c1, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hzd_check_scanner.md
# hzd_check_scanner

Debug-side reader for the hazard/data-select check mux. On a start pulse it walks `check_addr` across every check entry, captures each 32-bit `check_data` word, and streams a framed byte snapshot to a downstream byte sink (UART transmitter / debug FIFO) over a valid/ready handshake. It sits between the CPU debug mux and the board debug link.

## Interface

**Parameters**

- `NUM_ENTRIES`, default 25: number of check entries scanned, addresses 0..NUM_ENTRIES-1. Legal range 1..32.
- `HEADER`, default 8'hA5: frame start byte.

**Ports**

- `clk` input 1: system clock. Rising edge only.
- `rstn` input 1: reset. Asynchronous, active-low.
- `start` input 1: request one snapshot. Sampled only in IDLE.
- `check_addr` output 5: address driven to the check mux.
- `check_data` input 32: combinational mux response to `check_addr`.
- `tx_data` output 8: byte to sink.
- `tx_valid` output 1: `tx_data` valid.
- `tx_ready` input 1: sink accepts the byte.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle pulse when a frame completes.

## Operation

- **Frame format:** `HEADER`, then 4 bytes per entry in address order (little-endian, LSB first), then 1 checksum byte. The checksum is the XOR of all 4·NUM_ENTRIES data bytes; the header is excluded. Frame length is 4·NUM_ENTRIES+2 bytes (102 at the default).
- **IDLE:**
  - Outputs: `check_addr`=0, `tx_valid`=0.
  - On `start`=1, clear the checksum and go to HDR.
- **HDR:**
  - Outputs: `tx_valid`=1, `tx_data`=`HEADER`.
  - On acceptance, go to CAPT.
- **CAPT:**
  - Lasts exactly one cycle; `tx_valid`=0.
  - Register `word` ← `check_data`, then go to BYTE with `byte_idx`=0.
- **BYTE:**
  - Outputs: `tx_valid`=1, `tx_data`=`word[8·byte_idx +: 8]`.
  - On acceptance, XOR the byte into the checksum and increment `byte_idx`.
  - After byte 3 is accepted:
    - if `check_addr`==NUM_ENTRIES-1, go to SUM;
    - otherwise `check_addr`+1 and go to CAPT.
- **SUM:**
  - Outputs: `tx_valid`=1, `tx_data`=checksum.
  - On acceptance: go to IDLE, `check_addr`←0, `done` pulses 1 for the next cycle.
- **Handshake rules:**
  - A byte transfers on a rising edge where `tx_valid`&&`tx_ready`.
  - Once asserted, `tx_valid` and `tx_data` hold until accepted.
  - `tx_ready` is ignored while `tx_valid`=0.
- **Capture and address stability:**
  - `word` is captured only in CAPT. Changes on `check_data` during BYTE do not affect transmitted bytes.
  - `check_addr` is constant from CAPT through the last byte of that entry.
- **start:**
  - Ignored while `busy`=1; it is not queued.
  - A `start` held high through the completion cycle begins a new frame on the first IDLE cycle.
- **Reset:**
  - Values: state IDLE, `check_addr`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `done`=0, `word`=0, checksum=0, `byte_idx`=0.
  - Reset asserted mid-frame aborts immediately, with no partial completion and no `done`.

## Timing

- `start` sampled high at edge k: `tx_valid`=1 with `HEADER` visible after edge k, in the same cycle `busy` goes high.
- With `tx_ready` held at 1:
  - Header: 1 cycle.
  - Per entry: 5 cycles (1 CAPT + 4 BYTE).
  - Checksum: 1 cycle.
  - Total `busy` time: 5·NUM_ENTRIES+2 cycles (127 at the default).
  - `done` is high in the first IDLE cycle.
- Each cycle of `tx_ready`=0 during a valid byte adds exactly one cycle.
- `check_data` must settle within the CAPT cycle. The mux is combinational from a registered `check_addr`, so the path is one cycle.

## Test plan

- **Basic frame:**
  - Stimulus: bench drives `check_data`=32'h1000_0000+`check_addr`, `tx_ready`=1, pulse `start`.
  - Required response: 102 bytes — A5; 00 00 00 10; 01 00 00 10; … 18 00 00 10; checksum 08.
  - `busy` high for 127 cycles, `done` a single pulse, `check_addr` back to 0.
- **Backpressure:**
  - Stimulus: same setup, `tx_ready`=0 for 3 cycles while byte 0 of entry 5 is presented.
  - Required response: `tx_data`=05 and `tx_valid`=1 hold; `check_addr` stays 5; the frame is byte-identical to the basic frame; `busy` lasts 130 cycles.
- **Capture isolation:**
  - Stimulus: force `check_data`=32'hDEAD_BEEF during the BYTE states of entry 3 only, with the correct value during CAPT.
  - Required response: entry 3 is sent as 03 00 00 10.
- **Start while busy:**
  - Stimulus: pulse `start` at bytes 10 and 50 of a frame.
  - Required response: exactly one frame is sent and one `done` pulse occurs.
- **Reset mid-frame:**
  - Stimulus: assert `rstn`=0 asynchronously during entry 12.
  - Required response: outputs go to reset values immediately with no `done`.
  - A subsequent `start` yields a full correct frame with checksum 08.
- **Parameter check:**
  - Stimulus: NUM_ENTRIES=1, `check_data`=32'h1234_5678.
  - Required response: frame A5 78 56 34 12 08, `busy` 7 cycles.
